// File: rtl/latch_write_ctrl.sv
// latch_write_ctrl
//   Write controller sitting directly upstream of a d_latch bank. A word
//   accepted over valid/ready is parked on lat_d, then the latch enable is
//   opened from a flop for OPEN_CYC cycles. The data stays frozen for
//   SETUP_CYC cycles before the window and HOLD_CYC cycles after it.
//   Completion is flagged by a one-cycle done pulse and counted in wr_cnt.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   upstream word present
//   in_ready  out  controller idle, can accept a word (decoded from state)
//   in_data   in   word to write
//   lat_ena   out  latch enable, registered
//   lat_d     out  latch data, registered
//   done      out  one-cycle pulse per completed write
//   wr_cnt    out  completed-write count, wraps silently
module latch_write_ctrl #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             lat_ena,
    output logic [WIDTH-1:0] lat_d,
    output logic             done,
    output logic [CNT_W-1:0] wr_cnt
);

    // Phase counter sized for the longest of the three intervals.
    localparam int MAX_SO = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
    localparam int MAX_C  = (MAX_SO > HOLD_CYC) ? MAX_SO : HOLD_CYC;
    localparam int PH_W   = $clog2(MAX_C + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic              lat_ena_q, lat_ena_d;
    logic [WIDTH-1:0]  lat_d_q, lat_d_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

    // Counter is loaded with the interval length on entry; the phase ends
    // on the edge where it reads 1, so each phase lasts exactly N cycles.
    logic last_cyc;
    assign last_cyc = (ph_q == PH_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            lat_ena_q <= 1'b0;
            lat_d_q   <= '0;
            done_q    <= 1'b0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            lat_ena_q <= lat_ena_d;
            lat_d_q   <= lat_d_d;
            done_q    <= done_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        lat_ena_d = 1'b0;
        lat_d_d   = lat_d_q;
        done_d    = 1'b0;
        wr_cnt_d  = wr_cnt_q;
        case (state_q)
            IDLE: begin
                // lat_ena is already low here, so lat_d may change safely.
                if (in_valid) begin
                    lat_d_d = in_data;
                    state_d = SETUP;
                    ph_d    = PH_W'(SETUP_CYC);
                end
            end
            SETUP: begin
                if (last_cyc) begin
                    state_d   = OPEN;
                    ph_d      = PH_W'(OPEN_CYC);
                    lat_ena_d = 1'b1;
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            OPEN: begin
                if (last_cyc) begin
                    state_d = HOLD;
                    ph_d    = PH_W'(HOLD_CYC);
                end else begin
                    lat_ena_d = 1'b1;
                    ph_d      = ph_q - PH_W'(1);
                end
            end
            HOLD: begin
                if (last_cyc) begin
                    state_d  = IDLE;
                    ph_d     = '0;
                    done_d   = 1'b1;
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ph_d    = '0;
            end
        endcase
    end

    assign in_ready = (state_q == IDLE);
    assign lat_ena  = lat_ena_q;
    assign lat_d    = lat_d_q;
    assign done     = done_q;
    assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_latch_write_ctrl.sv
module tb_latch_write_ctrl;
    localparam int W   = 8;
    localparam int S   = 1;
    localparam int O   = 2;
    localparam int H   = 1;
    localparam int CW  = 2;
    localparam int TOT = S + O + H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          lat_ena;
    logic [W-1:0]  lat_d;
    logic          done;
    logic [CW-1:0] wr_cnt;

    always #5 clk = ~clk;

    latch_write_ctrl #(
        .WIDTH(W), .SETUP_CYC(S), .OPEN_CYC(O), .HOLD_CYC(H), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .lat_ena(lat_ena), .lat_d(lat_d), .done(done), .wr_cnt(wr_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Level-sensitive d_latch fed by the controller.
    logic [W-1:0] latch_q = '0;
    always @(lat_ena or lat_d) if (lat_ena) latch_q = lat_d;

    // Reference model: a word accepted at edge a occupies the controller
    // until edge a+TOT (done shows after that edge); lat_ena is high after
    // edges a+S .. a+S+O-1. Next accept possible at edge a+TOT+1.
    typedef struct { logic [W-1:0] d; logic [CW-1:0] c; } exp_t;
    exp_t         q[$];
    int           edge_n = 0;
    int           m_acc = 0;
    bit           m_act = 0;
    logic [W-1:0] m_lat = '0;
    int           m_cnt = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            edge_n++;
            if (in_valid && (!m_act || (edge_n - m_acc) > TOT)) begin
                m_cnt = (m_cnt + 1) % (1 << CW);
                q.push_back('{in_data, CW'(m_cnt)});
                m_acc = edge_n;
                m_act = 1;
                m_lat = in_data;
            end
        end
    end

    always @(negedge rst_n) begin
        m_act = 0;
        m_lat = '0;
        m_cnt = 0;
        q.delete();
    end

    // Monitor: per-cycle protocol checks, and scoreboard pop on each done.
    always @(negedge clk) begin
        int d;
        exp_t e;
        d = edge_n - m_acc;
        chk("lat_ena", 32'(lat_ena), 32'(m_act && d >= S && d < S + O));
        chk("in_ready", 32'(in_ready), 32'(!(m_act && d < TOT)));
        chk("lat_d", 32'(lat_d), 32'(m_lat));
        chk("done", 32'(done), 32'(m_act && d == TOT));
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL done_unexpected: got done=1 expected no pending write at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("wr_cnt", 32'(wr_cnt), 32'(e.c));
                chk("latch_out", 32'(latch_q), 32'(e.d));
            end
        end
    end

    task automatic send(input logic [W-1:0] dat, input int gap);
        bit r;
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = dat;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            if (r) ok = 1;
        end
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: got no accept expected accept of %0h", dat);
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit seen;
        // Reset with a word pending: must be ignored.
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_lat_ena", 32'(lat_ena), 0);
        chk("rst_lat_d", 32'(lat_d), 0);
        chk("rst_wr_cnt", 32'(wr_cnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;

        // Reset while the window is open.
        send(8'h5A, 0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (lat_ena === 1'b1) seen = 1;
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL open_timeout: got lat_ena=0 expected lat_ena=1 within 10 cycles");
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_lat_ena", 32'(lat_ena), 0);
        chk("midrst_lat_d", 32'(lat_d), 0);
        chk("midrst_wr_cnt", 32'(wr_cnt), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single write, then a new word presented during OPEN.
        send(8'hA5, 2);
        send(8'h3C, 0);
        // Back-to-back with in_valid held high.
        send(8'h01, 0);
        send(8'h02, 0);
        send(8'h03, 0);
        // Randomized traffic, wraps the 2-bit counter several times.
        for (int k = 0; k < 30; k++)
            send(W'($urandom), int'($urandom_range(0, 3)));

        repeat (TOT + 3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog");
    end
endmodule
